// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared types and constants for the bit-serial arithmetic
//               datapath (FSM state encoding, default width, counter sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    // Default operand width for arithmetic blocks
    localparam int ARITH_WIDTH_DEF = 8;

    // Control states for bit-serial operators
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width needed to index WIDTH serial steps
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Combinational 1-bit full subtractor: d = a - b - bin,
//               bout set when the bit position needs to borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first,
//               one bit per clock through a single full-subtractor cell.
//               Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_cnt_w = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Holds the WIDTH-1 result bits already produced; the last bit comes
    // straight from the cell on the final step.
    logic [WIDTH-2:0]   r_res;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_d;
    logic               w_br_nxt;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_full;

    full_subtractor u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_br_nxt)
    );

    assign w_last     = (r_cnt == c_cnt_w'(WIDTH - 1));
    assign w_res_full = {w_d, r_res};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh <= a;
                        r_b_sh <= b;
                        r_br   <= bin;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_br   <= w_br_nxt;
                    r_res  <= w_res_full[WIDTH-1:1];
                    r_cnt  <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        diff <= w_res_full;
                        bout <= w_br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        // Operand MSBs are the bits in the cell on the last step
                        ovf  <= (r_a_sh[0] ^ r_b_sh[0]) & (r_a_sh[0] ^ w_d);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8) using a
//               scoreboard of expected results popped on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        exp_t       e;
        t    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        e.d  = t[W-1:0];
        e.bo = t[W];
        e.ov = (x[W-1] ^ y[W-1]) & (x[W-1] ^ t[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive operands with start high; optionally record the expected result
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit push);
        start = 1'b1;
        a     = x;
        b     = y;
        bin   = c;
        if (push) sb.push_back(model(x, y, c));
    endtask

    // Wait for done; hold=0 drops start after the accepting edge,
    // hold=1 keeps start high and scrambles operands every cycle.
    task automatic wait_done(input bit hold, output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!hold && i == 1) start = 1'b0;
            if (hold) begin
                a   = W'($urandom);
                b   = W'($urandom);
                bin = 1'($urandom);
            end
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                lat = i;
                return;
            end
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, output int lat);
        int nb;
        launch(x, y, c, 1'b1);
        wait_done(1'b0, lat, nb);
    endtask

    // Scoreboard: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("diff", 64'(diff), 64'(mon_e.d));
                check("bout", 64'(bout), 64'(mon_e.bo));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 64'(ovf), 64'(mon_e.ov));
`endif
            end
        end
    end

    initial begin
        int     lat;
        int     nb;
        longint t_prev;
        logic [W-1:0] rx, ry;
        logic         rc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_bout", 64'(bout), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Basic op: latency and busy duration
        launch(8'h5A, 8'h3C, 1'b0, 1'b1);
        wait_done(1'b0, lat, nb);
        check("lat_basic", 64'(lat), 64'(W + 1));
        check("busy_cycles", 64'(nb), 64'(W));
        check("diff_basic", 64'(diff), 64'h1E);

        // Borrow cases
        @(negedge clk);
        run_op(8'h00, 8'h01, 1'b0, lat);
        check("lat_0m1", 64'(lat), 64'(W + 1));
        @(negedge clk);
        run_op(8'h10, 8'h10, 1'b1, lat);
        check("diff_bin", 64'(diff), 64'hFF);

`ifdef SERIAL_SUB_OVF_EN
        @(negedge clk);
        run_op(8'h80, 8'h01, 1'b0, lat);
        @(negedge clk);
        run_op(8'h7F, 8'hFF, 1'b0, lat);
`endif

        // Start held high with operands changing mid-op
        @(negedge clk);
        launch(8'h33, 8'h11, 1'b0, 1'b1);
        wait_done(1'b1, lat, nb);
        check("lat_held", 64'(lat), 64'(W + 1));
        launch(8'h40, 8'h01, 1'b1, 1'b1);
        @(negedge clk);
        check("idle_after_done", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("second_busy", 64'(busy), 64'd1);
        check("diff_hold", 64'(diff), 64'h22);
        wait_done(1'b0, lat, nb);
        check("lat_second", 64'(lat), 64'(W));

        // Reset aborts an operation in progress
        @(negedge clk);
        launch(8'h77, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_diff", 64'(diff), 64'd0);
        check("abort_bout", 64'(bout), 64'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_op(8'h05, 8'h03, 1'b0, lat);
        check("diff_after_abort", 64'(diff), 64'h02);
        t_prev = longint'($time);

        // Back-to-back operations from the first IDLE cycle after done
        for (int k = 0; k < 3; k++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom);
            @(negedge clk);
            run_op(rx, ry, rc, lat);
            check("done_spacing", 64'((longint'($time) - t_prev) / 10), 64'(W + 2));
            t_prev = longint'($time);
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
